// File: rtl/bus_if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_if_pkg                                                   |
// | Description : Shared types and default constants for the bus interface     |
// |               unit: transfer state encoding and default widths/timeout.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bus_if_pkg;

  localparam int c_def_addr_w  = 32;
  localparam int c_def_data_w  = 32;
  localparam int c_def_timeout = 16;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bus_if_unit_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wait_timer                                                   |
// | Description : Clear/enable wait-cycle counter with a terminal-count flag   |
// |               raised when the count equals TIMEOUT-1.                      |
// | Ports       : clk  - clock                                                 |
// |               rst  - asynchronous active-low reset                         |
// |               clr  - synchronous clear (wins over en)                      |
// |               en   - increment enable                                      |
// |               tc   - count == TIMEOUT-1                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wait_timer
  import bus_if_pkg::*;
#(
  parameter int TIMEOUT = c_def_timeout
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // ceil(log2(TIMEOUT)) bits hold 0..TIMEOUT-1; the owner stops enabling at
  // terminal count, so the counter never wraps.
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/bus_if_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_if_unit                                                  |
// | Description : Converts a held CPU read/write request into a single         |
// |               req/ack bus transfer with alignment checking, error          |
// |               response handling and a wait-cycle timeout.                  |
// | Ports       : clk, rst (async active-low)                                  |
// |               cpu_rd/cpu_wr/cpu_addr/cpu_wdata/cpu_be - CPU request        |
// |               cpu_rdata (registered), cpu_stall (comb), cpu_err (pulse)    |
// |               bus_req/bus_we/bus_addr/bus_wdata/bus_be - registered bus    |
// |               bus_ack/bus_err/bus_rdata - bus response                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bus_if_unit
  import bus_if_pkg::*;
#(
  parameter int ADDR_W  = c_def_addr_w,
  parameter int DATA_W  = c_def_data_w,
  parameter int TIMEOUT = c_def_timeout
) (
  input  logic                 clk,
  input  logic                rst,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                cpu_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int LN = DATA_W / 8;
  localparam int AL = $clog2(LN);   // address bits that must be zero

  state_e              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [LN-1:0]       bus_be_q, bus_be_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_err_q, cpu_err_d;

  logic                tmr_clr, tmr_en, tmr_tc;
  logic                req_any, req_bad;

  assign req_any = cpu_rd | cpu_wr;
  assign req_bad = (cpu_rd & cpu_wr) | (|cpu_addr[AL-1:0]) | ~(|cpu_be);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = 1'b0;          // pulse: only the cycle spent in ERR
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          if (req_bad) begin
            state_d   = ST_ERR;
            cpu_err_d = 1'b1;
          end else begin
            state_d     = ST_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = cpu_wr;
            bus_addr_d  = cpu_addr;
            bus_wdata_d = cpu_wdata;
            bus_be_d    = cpu_be;
            tmr_clr     = 1'b1;
          end
        end
      end

      ST_REQ: begin
        // An ack in the terminal-count cycle still completes the transfer.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (bus_err) begin
            state_d   = ST_ERR;
            cpu_err_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            if (!bus_we_q) begin
              cpu_rdata_d = bus_rdata;
            end
          end
        end else if (tmr_tc) begin
          bus_req_d = 1'b0;
          state_d   = ST_ERR;
          cpu_err_d = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      cpu_rdata_q <= '0;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
    end
  end

  // Stall is combinational so a new request is held off in its first cycle.
  assign cpu_stall = (state_q == ST_REQ) | ((state_q == ST_IDLE) & req_any);

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_err   = cpu_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

endmodule
`default_nettype wire

// File: doc/bus_if_unit.md
BUS_IF_UNIT -- requirements
Module: bus_if_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be 16, 32 or 64; lanes LN = DATA_W/8.
REQ-003 Parameter TIMEOUT, default 16, maximum bus_req cycles without bus_ack; range 2..255.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 cpu_rd  in  1  read request from controller (MemRead); held until stall low.
REQ-007 cpu_wr  in  1  write request from controller (MemWrite); held until stall low.
REQ-008 cpu_addr  in  ADDR_W  request address (MemAddr).
REQ-009 cpu_wdata  in  DATA_W  write data (WriteMem).
REQ-010 cpu_be  in  LN  byte enables, bit i = byte lane i.
REQ-011 cpu_rdata  out  DATA_W  read data (MemOut), registered.
REQ-012 cpu_stall  out  1  controller must hold its state and request while high.
REQ-013 cpu_err  out  1  one-cycle error pulse ending a transfer.
REQ-014 bus_req / bus_we  out  1 each  bus request, write qualifier.
REQ-015 bus_addr / bus_wdata / bus_be  out  ADDR_W / DATA_W / LN  registered transfer fields.
REQ-016 bus_ack / bus_err  in  1 each  completion, error-completion; sampled only while bus_req high.
REQ-017 bus_rdata  in  DATA_W  read data, valid with bus_ack.

Function
REQ-018 FSM states: IDLE, REQ, DONE, ERR.
REQ-019 IDLE: exactly one of cpu_rd/cpu_wr high, aligned address, cpu_be nonzero -> latch addr/wdata/be/we into bus_* registers, clear wait counter, go REQ.
REQ-020 IDLE: cpu_rd and cpu_wr both high, cpu_addr[log2(LN)-1:0] nonzero, or cpu_be all-zero -> go ERR; no bus_req issued.
REQ-021 REQ: bus_req high; bus fields stable; wait counter increments each cycle without bus_ack.
REQ-022 REQ: bus_ack=1, bus_err=0 -> go DONE; for reads capture bus_rdata into cpu_rdata in the same edge.
REQ-023 REQ: bus_ack=1, bus_err=1 -> go ERR; cpu_rdata unchanged.
REQ-024 REQ: counter reaches TIMEOUT-1 with no bus_ack -> go ERR; bus_req drops next cycle.
REQ-025 DONE and ERR: one cycle each, then IDLE unconditionally; requests present in these cycles are ignored.
REQ-026 cpu_err = 1 exactly in ERR, else 0.
REQ-027 cpu_stall = 1 in REQ, and in IDLE when cpu_rd or cpu_wr high; 0 in DONE, ERR, idle-without-request.
REQ-028 Latency: request seen in IDLE cycle 0, bus_req cycles 1..k, bus_ack in cycle k -> DONE in cycle k+1 (stall low); minimum 3 cycles per transfer.
REQ-029 cpu_rdata holds last successful read value until the next successful read.
REQ-030 bus_ack/bus_err while bus_req low SHALL be ignored.
REQ-031 Wait counter width = ceil(log2(TIMEOUT)); no wrap-around possible in REQ.

Reset
REQ-032 rst low: state IDLE, counter 0, bus_req 0, bus_we 0, bus_addr/bus_wdata/bus_be 0, cpu_rdata 0, cpu_err 0.
REQ-033 Reset during REQ SHALL drop bus_req immediately (asynchronous) with no DONE/ERR cycle.
REQ-034 First request accepted on the first rising edge with rst high.

Structure
REQ-035 Package bus_if_pkg: state enum, default ADDR_W/DATA_W/TIMEOUT constants.
REQ-036 One sub-module, wait_timer: clear/enable counter with terminal-count flag.
REQ-037 All outputs except cpu_stall SHALL be registered.

Verification
REQ-038 Read, addr 0x0000_0010, ack in the first REQ cycle with rdata 0xDEAD_BEEF -> cpu_rdata 0xDEAD_BEEF, stall low in cycle 2, total 3 cycles.
REQ-039 Write, addr 0x20, wdata 0x1234_5678, be 0xF, ack after 5 wait cycles -> bus fields stable throughout, one DONE cycle, cpu_err 0.
REQ-040 TIMEOUT=4, no ack -> bus_req high 4 cycles, cpu_err pulse 1 cycle, cpu_rdata unchanged.
REQ-041 cpu_rd=cpu_wr=1, or addr 0x3 -> ERR next cycle, bus_req never asserted.
REQ-042 rst low mid-REQ -> bus_req 0 asynchronously; after release, a read with ack completes normally.
REQ-043 DATA_W=64: read at 0x8 with be 0x0F succeeds; read at 0x4 -> ERR.
